// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg -- shared definitions for the interrupt controller.
//   * register addresses decoded on addr[1:0]
//   * bit positions of the NMI sources inside the NMIEN / NMIST bytes
//   * NMI pulse FSM state encoding
package int_ctrl_pkg;

  // Register map (read / write meaning noted per address)
  localparam logic [1:0] ADDR_IRQ    = 2'd0;  // W: IRQEN   R: IRQST
  localparam logic [1:0] ADDR_NMI    = 2'd1;  // W: NMIEN   R: NMIST
  localparam logic [1:0] ADDR_NMIRES = 2'd2;  // W: NMIRES  R: 0xFF
  localparam logic [1:0] ADDR_UNUSED = 2'd3;  // W: ignored R: 0xFF

  // NMI source bit positions inside NMIEN / NMIST
  localparam int NMI_BIT_DLI  = 7;  // nmi_src[2]
  localparam int NMI_BIT_VBI  = 6;  // nmi_src[1]
  localparam int NMI_BIT_RKEY = 5;  // nmi_src[0], always enabled

  // NMI pulse generator states
  typedef enum logic [1:0] {
    NMI_IDLE    = 2'd0,
    NMI_ASSERT  = 2'd1,
    NMI_HOLDOFF = 2'd2
  } nmi_state_t;

endpackage

// File: rtl/edge_detect.sv
// edge_detect -- per-bit rising-edge detector.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears history
//   din   : level inputs, synchronous to clk
//   rise  : 1 in the cycle where din[i] is high and was low one cycle earlier
// After reset the first clock only loads the history: an input that is
// already high when reset releases is not reported as an edge.
module edge_detect #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] hist_q;
  logic             armed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      hist_q  <= din;
      armed_q <= 1'b1;
    end
  end

  assign rise = din & ~hist_q & {WIDTH{armed_q}};

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl -- 6502-style IRQ / NMI interrupt controller.
//   phi2     : clock, all state updates on rising edge
//   rst      : asynchronous active-high reset
//   irq_src  : 8 peripheral IRQ request pulses
//   nmi_src  : NMI source levels [2]=DLI [1]=VBI [0]=reset key
//   sel/rw   : register strobe, rw=1 read / rw=0 write
//   addr     : register select (see int_ctrl_pkg)
//   data_in  : write data
//   data_out : combinational read data, 0x00 when not reading
//   IRQ_L    : registered active-low IRQ level
//   NMI_L    : registered active-low NMI pulse (NMI_PULSE low, NMI_GAP high)
// Optional feature macro: INT_CTRL_NMI_QUEUE_EN -- when defined, one enabled
// NMI edge arriving while a pulse/holdoff is in progress is remembered and
// issues a second pulse straight after holdoff.
//
// Bus handshake: a register access is a single-cycle strobe; sel=1 qualifies
// rw/addr/data_in for exactly that cycle, with no ready/back-pressure.
// The NMI FSM state register is state_q (type nmi_state_t) for checker binding.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NMI_PULSE = 2,  // legal 1..15
  parameter int NMI_GAP   = 4   // legal 1..15
) (
  input  logic       phi2,
  input  logic       rst,
  input  logic [7:0] irq_src,
  input  logic [2:0] nmi_src,
  input  logic       sel,
  input  logic       rw,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       IRQ_L,
  output logic       NMI_L
);

  localparam logic [3:0] PULSE_LOAD = 4'(NMI_PULSE - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(NMI_GAP - 1);

  // ---------------------------------------------------------------- decode
  logic wr, wr_irqen, wr_nmien, wr_nmires;
  assign wr        = sel & ~rw;
  assign wr_irqen  = wr && (addr == ADDR_IRQ);
  assign wr_nmien  = wr && (addr == ADDR_NMI);
  assign wr_nmires = wr && (addr == ADDR_NMIRES);

  // ---------------------------------------------------------------- IRQ
  logic [7:0] irqen_q, pend_q, pend_next, pend_set;
  logic       irq_l_q;

  // Set terms use the IRQEN value before any same-cycle write; a write
  // with data_in[i]=0 then masks the bit so the clear wins.
  always_comb begin
    pend_set  = irq_src & irqen_q;
    pend_next = pend_q | pend_set;
    if (wr_irqen) pend_next = pend_next & data_in;
  end

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      irqen_q <= 8'h00;
      pend_q  <= 8'h00;
      irq_l_q <= 1'b1;
    end else begin
      if (wr_irqen) irqen_q <= data_in;
      pend_q  <= pend_next;
      irq_l_q <= ~|(pend_q & irqen_q);
    end
  end

  assign IRQ_L = irq_l_q;

  // ---------------------------------------------------------------- NMI edges
  logic [2:0] nmi_rise, nmi_edge;
  logic [1:0] nmien_q;  // {DLI, VBI}; reset key has no enable
  logic [2:0] nmist_q;
  logic       any_edge;

  edge_detect #(.WIDTH(3)) u_edge (
    .clk  (phi2),
    .rst  (rst),
    .din  (nmi_src),
    .rise (nmi_rise)
  );

  assign nmi_edge = nmi_rise & {nmien_q, 1'b1};
  assign any_edge = |nmi_edge;

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      nmien_q <= 2'b00;
      nmist_q <= 3'b000;
    end else begin
      if (wr_nmien) nmien_q <= {data_in[NMI_BIT_DLI], data_in[NMI_BIT_VBI]};
      // An edge in the same cycle as NMIRES survives the clear.
      nmist_q <= (wr_nmires ? 3'b000 : nmist_q) | nmi_edge;
    end
  end

  // ---------------------------------------------------------------- NMI FSM
  nmi_state_t state_q, state_next;
  logic [3:0] cnt_q, cnt_next;
  logic       nmi_l_q;

`ifdef INT_CTRL_NMI_QUEUE_EN
  logic queued_q, queued_next;

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) queued_q <= 1'b0;
    else     queued_q <= queued_next;
  end
`endif

  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
`ifdef INT_CTRL_NMI_QUEUE_EN
    queued_next = queued_q;
`endif
    case (state_q)
      NMI_IDLE: begin
        if (any_edge) begin
          state_next = NMI_ASSERT;
          cnt_next   = PULSE_LOAD;
        end
      end
      NMI_ASSERT: begin
`ifdef INT_CTRL_NMI_QUEUE_EN
        queued_next = queued_q | any_edge;
`endif
        if (cnt_q == 4'd0) begin
          state_next = NMI_HOLDOFF;
          cnt_next   = GAP_LOAD;
        end else begin
          cnt_next = cnt_q - 4'd1;
        end
      end
      NMI_HOLDOFF: begin
`ifdef INT_CTRL_NMI_QUEUE_EN
        queued_next = queued_q | any_edge;
`endif
        if (cnt_q == 4'd0) begin
`ifdef INT_CTRL_NMI_QUEUE_EN
          // An edge in the final holdoff cycle counts as queued too.
          if (queued_q | any_edge) begin
            state_next  = NMI_ASSERT;
            cnt_next    = PULSE_LOAD;
            queued_next = 1'b0;
          end else begin
            state_next = NMI_IDLE;
            cnt_next   = 4'd0;
          end
`else
          state_next = NMI_IDLE;
          cnt_next   = 4'd0;
`endif
        end else begin
          cnt_next = cnt_q - 4'd1;
        end
      end
      default: begin
        state_next = NMI_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // NMI_L is its own flop fed from the next state so the pin is glitch-free
  // and goes low in the cycle the FSM enters ASSERT.
  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      state_q <= NMI_IDLE;
      cnt_q   <= 4'd0;
      nmi_l_q <= 1'b1;
    end else begin
      state_q <= state_next;
      cnt_q   <= cnt_next;
      nmi_l_q <= (state_next != NMI_ASSERT);
    end
  end

  assign NMI_L = nmi_l_q;

  // ---------------------------------------------------------------- read mux
  always_comb begin
    data_out = 8'h00;
    if (sel && rw) begin
      case (addr)
        ADDR_IRQ: data_out = ~pend_q;
        ADDR_NMI: begin
          data_out[NMI_BIT_DLI]  = nmist_q[2];
          data_out[NMI_BIT_VBI]  = nmist_q[1];
          data_out[NMI_BIT_RKEY] = nmist_q[0];
        end
        ADDR_NMIRES: data_out = 8'hFF;
        ADDR_UNUSED: data_out = 8'hFF;
        default:     data_out = 8'hFF;
      endcase
    end
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL provide parameter NMI_PULSE, default 2: cycles NMI_L is held low per NMI event (legal 1-15).
REQ-002 SHALL provide parameter NMI_GAP, default 4: cycles NMI_L is held high after a pulse before another pulse may start (legal 1-15).
REQ-003 SHALL have ports:
  phi2      in   1  clock; all state updates on its rising edge.
  rst       in   1  asynchronous, active-high reset.
  irq_src   in   8  peripheral IRQ requests; one-cycle pulses, synchronous to phi2.
  nmi_src   in   3  NMI sources: [2]=DLI, [1]=VBI, [0]=reset key; level, synchronous.
  sel       in   1  register access strobe, one cycle.
  rw        in   1  1=read, 0=write (6502 convention).
  addr      in   2  register select.
  data_in   in   8  write data.
  data_out  out  8  read data.
  IRQ_L     out  1  active-low level IRQ to CPU.
  NMI_L     out  1  active-low NMI pulse to CPU.

Function
REQ-004 SHALL map registers: addr 0 write=IRQEN, read=IRQST; addr 1 write=NMIEN, read=NMIST; addr 2 write=NMIRES (data ignored), read=0xFF; addr 3 write ignored, read=0xFF.
REQ-005 SHALL set pend[i] at a clock edge where irq_src[i]=1 and IRQEN[i]=1; pend[i] holds until cleared.
REQ-006 SHALL clear pend[i] on an IRQEN write with data_in[i]=0; same-cycle irq_src[i] pulse plus this write: clear wins; write with data_in[i]=1: pulse sets pend[i] if IRQEN[i] was already 1.
REQ-007 SHALL read IRQST as ~pend (active-low status).
REQ-008 SHALL drive IRQ_L registered: IRQ_L = ~|(pend & IRQEN), one cycle after pend/IRQEN change.
REQ-009 SHALL detect rising edges of nmi_src per bit against a one-cycle-delayed copy; NMIEN bits data_in[7:5] map to nmi_src[2:0]; nmi_src[0] (reset key) is always enabled.
REQ-010 SHALL set NMIST[7:5] bit on an enabled edge of the matching source; NMIST[4:0] read 0.
REQ-011 SHALL clear NMIST[7:5] on an NMIRES write; same-cycle enabled edge: edge's bit ends set.
REQ-012 SHALL run NMI FSM: IDLE (NMI_L=1) -> ASSERT on any enabled edge; ASSERT (NMI_L=0) for exactly NMI_PULSE cycles -> HOLDOFF; HOLDOFF (NMI_L=1) for exactly NMI_GAP cycles -> IDLE.
REQ-013 SHALL register NMI_L; first low cycle follows the edge-detect cycle by one clock.
REQ-014 SHALL, with several enabled edges in one cycle, issue one pulse and set all matching NMIST bits.
REQ-015 SHALL drive data_out combinationally when sel=1 and rw=1, else 0x00.
REQ-016 SHALL use saturating-free wrap-safe 4-bit counters, reloaded on each state entry.

Reset
REQ-017 SHALL on rst: IRQEN=0, NMIEN=0, pend=0, NMIST=0, edge history=0, FSM=IDLE, counters=0, IRQ_L=1, NMI_L=1.
REQ-018 SHALL abort any pulse when rst asserts mid-ASSERT: NMI_L returns to 1 immediately (async).
REQ-019 SHALL resume in IDLE on rst release; a source already high at release SHALL NOT count as an edge.

Configuration
REQ-020 SHALL honour macro INT_CTRL_NMI_QUEUE_EN: defined -> one-deep queue; an enabled edge during ASSERT/HOLDOFF sets a queued flag, and HOLDOFF exits to ASSERT instead of IDLE if set (flag cleared); undefined -> such edges update NMIST only, no pulse.

Structure
REQ-021 SHALL place register addresses, NMIEN/NMIST bit positions and FSM state encoding in shared package int_ctrl_pkg.
REQ-022 SHALL implement edge detection in sub-module edge_detect (width parameter, rst-cleared history).

Verification
REQ-023 IRQEN=0x01, irq_src=0x01 pulse -> next cycle IRQST=0xFE, IRQ_L=0 following cycle; write IRQEN=0x00 -> IRQST=0xFF, IRQ_L=1.
REQ-024 NMIEN=0x40, nmi_src[1] rises -> NMI_L low exactly 2 cycles, then high 4; NMIST=0x40; NMIRES -> NMIST=0x00.
REQ-025 NMIEN=0x00, nmi_src[2] rises -> no pulse, NMIST=0x00; nmi_src[0] rises -> pulse, NMIST=0x20.
REQ-026 Second enabled edge 1 cycle into HOLDOFF -> with INT_CTRL_NMI_QUEUE_EN second pulse starts right after HOLDOFF; without, no second pulse, NMIST bit set.
REQ-027 rst asserted during ASSERT -> NMI_L=1 and IRQ_L=1 same cycle, all registers read reset values; nmi_src held high across release -> no pulse.
